// File: rtl/int_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler.
//   state_e      : scheduler FSM encoding
//   CFG_*        : configuration write-port address map
//   TIMER_SRC    : interrupt source index driven by the quantum timer
package int_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [2:0] CFG_VEC0    = 3'd0;
  localparam logic [2:0] CFG_QUANTUM = 3'd4;
  localparam logic [2:0] CFG_CTRL    = 3'd5;

  localparam int TIMER_SRC = 0;

endpackage

// File: rtl/int_scheduler_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req : request vector, bit 0 has highest priority
//   any : at least one request present
//   idx : index of the lowest set bit (0 when no request)
module prio_enc #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  output logic                       any,
  output logic [$clog2(NUM_SRC)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_SRC);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_scheduler.sv
// Interrupt scheduler: sticky pending bits, a quantum timer on source 0,
// lowest-index arbitration and an offer/ack/eoi handshake with the program
// counter.
//   clock, reset_n         : clock and async active-low reset
//   init_flag, user_mode   : run enable / user process active
//   irq_req, irq_mask      : request pulses and per-source enables
//   cfg_we/addr/wdata      : vector, quantum and timer-enable writes
//   int_valid/pos/src      : interrupt offered to the program counter
//   int_ack, eoi           : offer taken / service finished
//   pending, busy          : status
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | arbitrating; timer may count
// ST_OFFER   | int_valid high, int_src/int_pos frozen until int_ack
// ST_SERVICE | handler running (busy), waiting for eoi
module int_scheduler
  import int_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       init_flag,
  input  logic                       user_mode,
  input  logic [NUM_SRC-1:0]         irq_req,
  input  logic [NUM_SRC-1:0]         irq_mask,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic [VEC_W-1:0]           cfg_wdata,
  output logic                       int_valid,
  output logic [VEC_W-1:0]           int_pos,
  output logic [$clog2(NUM_SRC)-1:0] int_src,
  input  logic                       int_ack,
  input  logic                       eoi,
  output logic [NUM_SRC-1:0]         pending,
  output logic                       busy
);

  localparam int SRC_W = $clog2(NUM_SRC);

  state_e             state;
  logic [VEC_W-1:0]   vector [NUM_SRC];
  logic [VEC_W-1:0]   quantum;
  logic [VEC_W-1:0]   counter;
  logic               timer_en;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] clr_mask;
  logic               win_any;
  logic [SRC_W-1:0]   win_idx;
  logic [VEC_W-1:0]   win_vec;
  logic               quantum_we;
  logic               cnt_en;
  logic               timer_fire;
  logic               take_offer;
  logic               take_ack;
  logic               take_eoi;

  assign eligible = pending & irq_mask;

  prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_idx == SRC_W'(i)) win_vec = vector[i];
    end
  end

  assign quantum_we = cfg_we && (cfg_addr == CFG_QUANTUM);
  assign cnt_en     = init_flag && user_mode && timer_en &&
                      (quantum != '0) && (state == ST_IDLE);
  // A quantum write on the same edge restarts the period, so it suppresses
  // the expiry that the old count would have produced.
  assign timer_fire = cnt_en && !quantum_we && (counter == VEC_W'(1));

  assign take_offer = init_flag && user_mode && (state == ST_IDLE) && win_any;
  assign take_ack   = init_flag && (state == ST_OFFER) && int_ack;
  assign take_eoi   = init_flag && (state == ST_SERVICE) && eoi;

  always_comb begin
    set_mask = irq_req;
    if (timer_fire) set_mask[TIMER_SRC] = 1'b1;
    clr_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take_ack && (int_src == SRC_W'(i))) clr_mask[i] = 1'b1;
    end
  end

  // Configuration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quantum  <= '0;
      timer_en <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) vector[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == CFG_QUANTUM) quantum  <= cfg_wdata;
      if (cfg_addr == CFG_CTRL)    timer_en <= cfg_wdata[0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if ((i < int'(CFG_QUANTUM)) && (cfg_addr == CFG_VEC0 + 3'(i))) vector[i] <= cfg_wdata;
      end
    end
  end

  // Quantum down-counter; reload on expiry or on a quantum write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (quantum_we) begin
      counter <= cfg_wdata;
    end else if (cnt_en) begin
      if (counter <= VEC_W'(1)) counter <= quantum;
      else                      counter <= counter - VEC_W'(1);
    end
  end

  // Set wins over the acknowledge clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      int_src <= '0;
      int_pos <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_offer) begin
            state   <= ST_OFFER;
            int_src <= win_idx;
            int_pos <= win_vec;
          end
        end
        ST_OFFER:   if (take_ack) state <= ST_SERVICE;
        ST_SERVICE: if (take_eoi) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign int_valid = (state == ST_OFFER);
  assign busy      = (state == ST_SERVICE);

endmodule

// File: tb/tb_int_scheduler.sv
module tb_int_scheduler;

  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 16;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               init_flag = 1'b0;
  logic               user_mode = 1'b0;
  logic [NUM_SRC-1:0] irq_req = '0;
  logic [NUM_SRC-1:0] irq_mask = '0;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_addr = '0;
  logic [VEC_W-1:0]   cfg_wdata = '0;
  logic               int_ack = 1'b0;
  logic               eoi = 1'b0;
  logic               int_valid;
  logic [VEC_W-1:0]   int_pos;
  logic [1:0]         int_src;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  typedef struct packed {
    logic [1:0]       src;
    logic [VEC_W-1:0] pos;
  } offer_t;

  offer_t           exp_q[$];
  logic [VEC_W-1:0] model_vec [NUM_SRC];
  int               n_checks = 0;
  int               n_fail = 0;
  logic             prev_valid = 1'b0;

  int_scheduler #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_flag (init_flag),
    .user_mode (user_mode),
    .irq_req   (irq_req),
    .irq_mask  (irq_mask),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .int_valid (int_valid),
    .int_pos   (int_pos),
    .int_src   (int_src),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Scoreboard: every new offer is matched against the oldest expectation.
  always @(posedge clock) begin
    #1;
    if (int_valid && !prev_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: offer src=%0d pos=%h, nothing expected", int_src, int_pos);
      end else begin
        offer_t e;
        e = exp_q.pop_front();
        if (int_src !== e.src || int_pos !== e.pos) begin
          n_fail++;
          $display("FAIL sb_offer: got src=%0d pos=%h, expected src=%0d pos=%h", int_src, int_pos, e.src, e.pos);
        end
      end
    end
    prev_valid = int_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [VEC_W-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    if (addr < 3'd4) model_vec[addr[1:0]] = data;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] req);
    irq_req = req;
    tick();
    irq_req = '0;
  endtask

  task automatic ack_and_eoi();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1;     tick(); eoi = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] src);
    offer_t e;
    e.src = src;
    e.pos = model_vec[src];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    irq_req = '1;
    tick(); tick();
    n_checks++;
    if ({int_valid, busy, int_src, int_pos, pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b busy=%b src=%0d pos=%h pend=%b, expected all 0",
               int_valid, busy, int_src, int_pos, pending);
    end
    irq_req = '0;
    reset_n = 1'b1;
    init_flag = 1'b1;
    irq_mask = '1;
    for (int i = 0; i < NUM_SRC; i++) cfg_write(3'(i), 16'h1000 + 16'(i) * 16'h0111);
    tick();
    n_checks++;
    if (int_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%b pend=%b, expected 0 0000", int_valid, pending);
    end
  endtask

  task automatic test_priority();
    user_mode = 1'b1;
    push_exp(2'd1);
    push_exp(2'd3);
    pulse(4'b1010);
    n_checks++;
    if (pending !== 4'b1010 || int_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_pending: got pend=%b valid=%b, expected 1010 0", pending, int_valid);
    end
    tick();
    n_checks++;
    if (int_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_latency: got valid=%b, expected 1", int_valid);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || int_valid !== 1'b0 || pending !== 4'b1000) begin
      n_fail++;
      $display("FAIL prio_ack: got busy=%b valid=%b pend=%b, expected 1 0 1000", busy, int_valid, pending);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_eoi: got busy=%b, expected 0", busy);
    end
    tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_src !== 2'd3) begin
      n_fail++;
      $display("FAIL prio_second: got valid=%b src=%0d, expected 1 3", int_valid, int_src);
    end
    ack_and_eoi();
    n_checks++;
    if (pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_drained: got pend=%b, expected 0000", pending);
    end
  endtask

  task automatic test_timer();
    cfg_write(3'd5, 16'h0001);
    cfg_write(3'd4, 16'd5);
    push_exp(2'd0);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_early: got pend0=%b after 4 cycles, expected 0", pending[0]);
    end
    tick();
    n_checks++;
    if (pending[0] !== 1'b1 || int_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_expire: got pend0=%b valid=%b after 5 cycles, expected 1 0", pending[0], int_valid);
    end
    tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_pos !== model_vec[0]) begin
      n_fail++;
      $display("FAIL timer_offer: got valid=%b pos=%h, expected 1 %h", int_valid, int_pos, model_vec[0]);
    end
    ack_and_eoi();
    cfg_write(3'd4, 16'd0);
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (pending !== 4'b0000 || int_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_q0: got pend=%b valid=%b with quantum 0, expected 0000 0", pending, int_valid);
    end
    cfg_write(3'd5, 16'h0000);
  endtask

  task automatic test_mask_hold();
    push_exp(2'd2);
    push_exp(2'd0);
    pulse(4'b0100);
    tick();
    irq_mask = 4'b1011;
    pulse(4'b0001);
    tick(); tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_src !== 2'd2 || int_pos !== model_vec[2]) begin
      n_fail++;
      $display("FAIL mask_hold: got valid=%b src=%0d pos=%h, expected 1 2 %h", int_valid, int_src, int_pos, model_vec[2]);
    end
    irq_mask = '1;
    ack_and_eoi();
    tick();
    ack_and_eoi();
    n_checks++;
    if (pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL mask_drained: got pend=%b, expected 0000", pending);
    end
  endtask

  task automatic test_set_wins();
    push_exp(2'd1);
    push_exp(2'd1);
    pulse(4'b0010);
    tick();
    int_ack = 1'b1; irq_req = 4'b0010;
    tick();
    int_ack = 1'b0; irq_req = '0;
    n_checks++;
    if (pending[1] !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: got pend1=%b busy=%b, expected 1 1", pending[1], busy);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_src !== 2'd1) begin
      n_fail++;
      $display("FAIL set_wins_reoffer: got valid=%b src=%0d, expected 1 1", int_valid, int_src);
    end
    ack_and_eoi();
  endtask

  task automatic test_user_mode();
    push_exp(2'd2);
    push_exp(2'd0);
    user_mode = 1'b0;
    cfg_write(3'd5, 16'h0001);
    cfg_write(3'd4, 16'd3);
    pulse(4'b0100);
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (int_valid !== 1'b0 || pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL user_frozen: got valid=%b pend=%b, expected 0 0100", int_valid, pending);
    end
    user_mode = 1'b1;
    tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_src !== 2'd2) begin
      n_fail++;
      $display("FAIL user_release: got valid=%b src=%0d, expected 1 2", int_valid, int_src);
    end
    ack_and_eoi();
    for (int i = 0; i < 10 && !int_valid; i++) tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_src !== 2'd0) begin
      n_fail++;
      $display("FAIL user_timer_resume: got valid=%b src=%0d, expected 1 0 within 10 cycles", int_valid, int_src);
    end
    ack_and_eoi();
    cfg_write(3'd4, 16'd0);
    cfg_write(3'd5, 16'h0000);
  endtask

  task automatic test_init_freeze();
    init_flag = 1'b0;
    push_exp(2'd3);
    pulse(4'b1000);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (pending !== 4'b1000 || int_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_freeze: got pend=%b valid=%b, expected 1000 0", pending, int_valid);
    end
    init_flag = 1'b1;
    tick();
    n_checks++;
    if (int_valid !== 1'b1 || int_pos !== model_vec[3]) begin
      n_fail++;
      $display("FAIL init_release: got valid=%b pos=%h, expected 1 %h", int_valid, int_pos, model_vec[3]);
    end
    ack_and_eoi();
  endtask

  task automatic test_reset_mid_service();
    push_exp(2'd1);
    pulse(4'b0010);
    tick();
    int_ack = 1'b1; irq_req = 4'b1000;
    tick();
    int_ack = 1'b0; irq_req = '0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({int_valid, busy, int_src, int_pos, pending} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b busy=%b src=%0d pos=%h pend=%b, expected all 0",
               int_valid, busy, int_src, int_pos, pending);
    end
    tick();
    reset_n = 1'b1;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || int_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_eoi_ignored: got busy=%b valid=%b pend=%b, expected 0 0 0000", busy, int_valid, pending);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) model_vec[i] = '0;
    test_reset();
    test_priority();
    test_timer();
    test_mask_hold();
    test_set_wins();
    test_user_mode();
    test_init_freeze();
    test_reset_mid_service();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d offers still expected, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
